vx_result_merge: RTL and testbench
==================================

// Module: VX_result_merge
// PURPOSE
//  Merges NUM_INPUTS writeback result streams (execute-unit results: uuid, wid, tmask, PC,
//  wb, rd, data, pid, sop, eop) into a single result stream for the commit/writeback stage.
//  Each input is decoupled by a 2-entry skid buffer. A round-robin arbiter selects the
//  winner. Multi-beat results (sop..eop over pid) are never interleaved with other inputs.
//  An optional registered output stage follows the arbiter.
// PARAMETERS
//  NUM_INPUTS  4                                 number of result sources (>=1)
//  NUM_LANES   `SIMD_WIDTH                       lanes per beat
//  PID_WIDTH   `LOG2UP(`NUM_THREADS/NUM_LANES)   beat (packet index) width
//  OUT_BUF     1                                 1: registered output; 0: combinational from arbiter
//  DATAW       RESULT_DATAW(NUM_LANES,PID_WIDTH) packed beat width (derived, do not override)
// PORTS
//  clk        in   1                   clock
//  reset      in   1                   synchronous, active-high reset
//  in_valid   in   NUM_INPUTS          per-input beat valid
//  in_data    in   NUM_INPUTS x DATAW  per-input packed beat {uuid,wid,tmask,PC,wb,rd,data,pid,sop,eop}
//  in_ready   out  NUM_INPUTS          per-input accept (registered, = buffer not full)
//  out_valid  out  1                   merged beat valid
//  out_data   out  DATAW               merged beat
//  out_sel    out  `LOG2UP(NUM_INPUTS) source index of out_data
//  out_ready  in   1                   downstream accept
// BEHAVIOUR
//  - Reset (sync, active-high): out_valid=0, out_sel=0, in_ready=0 while reset=1, buffers empty,
//    rr_ptr=0, lock=0. First cycle after reset: in_ready=all 1s. Reset mid-packet drops all beats.
//  - Transfer on valid&&ready. Inputs must hold valid/data stable until accepted (assert in sim).
//  - Skid buffer: 2 entries per input, count 0..2. Push on in_valid&&in_ready; pop on grant-transfer.
//    in_ready = (count<2), registered. Push+pop in same cycle: count unchanged, order preserved.
//    Full (count==2): in_ready=0 next cycle; a pop re-raises it the following cycle. No loss.
//  - Arbiter: candidates = inputs with non-empty buffer. If lock=0: pick first candidate scanning
//    rr_ptr, rr_ptr+1, ... (mod NUM_INPUTS). Grant transfers when arbiter output is accepted
//    (OUT_BUF=1: output reg empty or out_ready; OUT_BUF=0: out_ready).
//  - Lock FSM: IDLE --(granted beat with eop=0)--> LOCKED(owner=winner).
//    LOCKED --(owner beat with eop=1 transferred)--> IDLE.
//    In LOCKED only owner is served; owner buffer empty => output bubble, others held.
//  - rr_ptr <= winner+1 (mod NUM_INPUTS) only on transfer of a beat with eop=1.
//  - Single-beat results have sop=eop=1. Assert: first beat into IDLE has sop=1; beats while
//    LOCKED have sop=0; pid increments by 1 within a packet.
//  - Latency in_valid accept -> out_valid: 2 cycles (OUT_BUF=1), 1 cycle (OUT_BUF=0), uncontended.
//    Throughput: 1 beat/cycle sustained.
//  - OUT_BUF=1 output reg loads when !out_valid || out_ready; out_sel is registered with data.
//  - NUM_INPUTS==1: arbiter/lock degenerate to pass-through; out_sel=0.
// STRUCTURE
//  - VX_gpu_pkg: RESULT_DATAW(lanes,pid_w) function and result_data_t packed struct
//    (field order above), shared with the result interface.
//  - Sub-module VX_result_skid: 2-entry skid buffer (DATAW), one instance per input.
//  - Arbiter, lock FSM and output register live in this module.
// TESTING
//  1 One input, 4 single-beat results b2b, out_ready=1 -> 4 beats at t+2..t+5, order kept, out_sel=0.
//  2 All 4 inputs valid single-beat every cycle, out_ready=1 -> out_sel 0,1,2,3,0,1,... 1 beat/cycle.
//  3 Input1 3-beat packet (pid 0,1,2; sop@0, eop@2), inputs 0,2 busy ->
//    input1 beats contiguous, then rr resumes at 2.
//  4 out_ready=0 for 10 cycles, all inputs pushing -> each in_ready drops after 2 accepts;
//    release -> 8(+1 reg) beats drain, none lost or reordered per input.
//  5 Locked owner gaps 3 cycles mid-packet, others valid -> out_valid=0 for gap, no other
//    source granted.
//  6 reset=1 mid-packet for 1 cycle -> next cycle out_valid=0, in_ready=0;
//    cycle after release in_ready=1; lock cleared, new packet from any input accepted.

Source files
------------

// File: rtl/vx_result_merge_pkg.sv
// Shared definitions for the result merge block and the result interface.
//  - log2up()        : index width helper, never smaller than 1
//  - result_dataw()  : packed beat width for a given lane count and pid width
//  - result_data_t   : packed beat {uuid,wid,tmask,PC,wb,rd,data,pid,sop,eop}
//  - lock_state_e    : packet lock state of the merge arbiter
package vx_result_merge_pkg;

  localparam int UUID_W          = 8;
  localparam int NW_W            = 2;
  localparam int PC_W            = 32;
  localparam int WB_W            = 1;
  localparam int RD_W            = 5;
  localparam int XLEN            = 32;
  localparam int FLAG_W          = 2;
  localparam int RES_NUM_LANES   = 4;
  localparam int RES_NUM_THREADS = 16;
  localparam int EOP_BIT         = 0;

  function automatic int log2up(input int v);
    return (v > 32'sd1) ? $clog2(v) : 32'sd1;
  endfunction

  localparam int RES_PID_WIDTH = log2up(RES_NUM_THREADS / RES_NUM_LANES);

  function automatic int result_dataw(input int lanes, input int pid_w);
    return UUID_W + NW_W + lanes + PC_W + WB_W + RD_W + (lanes * XLEN) + pid_w + FLAG_W;
  endfunction

  typedef struct packed {
    logic [UUID_W-1:0]                  uuid;
    logic [NW_W-1:0]                    wid;
    logic [RES_NUM_LANES-1:0]           tmask;
    logic [PC_W-1:0]                    pc;
    logic                               wb;
    logic [RD_W-1:0]                    rd;
    logic [RES_NUM_LANES*XLEN-1:0]      data;
    logic [RES_PID_WIDTH-1:0]           pid;
    logic                               sop;
    logic                               eop;
  } result_data_t;

  typedef enum logic [0:0] {
    LOCK_IDLE  = 1'b0,
    LOCK_OWNED = 1'b1
  } lock_state_e;

endpackage

// File: rtl/vx_result_merge_skid.sv
// Two-entry skid buffer decoupling one result source from the merge arbiter.
//  clk, reset : clock, synchronous active-high reset
//  in_valid   : source beat valid        in_data  : source beat
//  in_ready   : registered, high while fewer than two entries are held
//  out_valid  : buffer holds a beat      out_data : oldest held beat
//  pop        : arbiter consumed out_data this cycle
module vx_result_merge_skid
  import vx_result_merge_pkg::*;
#(
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [DATAW-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DATAW-1:0] out_data,
  input  logic             pop
);

  logic [1:0]       count_r;
  logic [1:0]       count_next_s;
  logic [DATAW-1:0] head_r;
  logic [DATAW-1:0] tail_r;
  logic             in_ready_r;
  logic             push_s;
  logic             pop_s;

  assign push_s    = in_valid && in_ready_r;
  assign pop_s     = pop && (count_r != 2'd0);
  assign in_ready  = in_ready_r;
  assign out_valid = (count_r != 2'd0);
  assign out_data  = head_r;

  // Occupancy after this cycle's push/pop
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + 2'd1;
      2'b01:   count_next_s = count_r - 2'd1;
      default: count_next_s = count_r;
    endcase
  end

  // Entry storage; in_ready is registered from the next occupancy, so a full
  // buffer never sees a push and head/tail shifting covers every other case
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r    <= 2'd0;
      in_ready_r <= 1'b0;
      head_r     <= '0;
      tail_r     <= '0;
    end else begin
      count_r    <= count_next_s;
      in_ready_r <= (count_next_s != 2'd2);
      if (pop_s) begin
        if (count_r == 2'd2) begin
          head_r <= tail_r;
        end else if (push_s) begin
          head_r <= in_data;
        end
      end else if (push_s) begin
        if (count_r == 2'd0) begin
          head_r <= in_data;
        end else begin
          tail_r <= in_data;
        end
      end
    end
  end

endmodule

// File: rtl/vx_result_merge.sv
// Merges NUM_INPUTS result streams into one writeback stream. Each source is
// decoupled by a skid buffer, a round-robin arbiter picks the winner and a
// lock keeps multi-beat packets (sop..eop) contiguous on the output.
//  clk, reset : clock, synchronous active-high reset
//  in_valid   : per-source beat valid      in_data : per-source packed beat
//  in_ready   : per-source accept (registered)
//  out_valid  : merged beat valid          out_data : merged beat
//  out_sel    : source index of out_data   out_ready : downstream accept
module vx_result_merge
  import vx_result_merge_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int NUM_LANES  = RES_NUM_LANES,
  parameter int PID_WIDTH  = RES_PID_WIDTH,
  parameter int OUT_BUF    = 1,
  parameter int DATAW      = result_dataw(NUM_LANES, PID_WIDTH),
  parameter int SEL_W      = log2up(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  input  logic [NUM_INPUTS-1:0][DATAW-1:0] in_data,
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic                             out_valid,
  output logic [DATAW-1:0]                 out_data,
  output logic [SEL_W-1:0]                 out_sel,
  input  logic                             out_ready
);

  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W + 1)'(NUM_INPUTS);

  logic [NUM_INPUTS-1:0] buf_valid_s;
  logic [NUM_INPUTS-1:0] pop_s;
  logic [DATAW-1:0]      buf_data_s [NUM_INPUTS];

  lock_state_e      lock_state_r;
  lock_state_e      lock_next_s;
  logic             locked_s;
  logic [SEL_W-1:0] owner_r;
  logic [SEL_W-1:0] rr_ptr_r;
  logic [SEL_W:0]   scan_idx_s;
  logic [SEL_W:0]   ptr_inc_s;
  logic [SEL_W-1:0] next_ptr_s;

  logic             grant_valid_s;
  logic [SEL_W-1:0] grant_idx_s;
  logic [DATAW-1:0] grant_data_s;
  logic             grant_eop_s;
  logic             arb_ready_s;
  logic             fire_s;

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_skid
    vx_result_merge_skid #(.DATAW(DATAW)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid[gi]),
      .in_data   (in_data[gi]),
      .in_ready  (in_ready[gi]),
      .out_valid (buf_valid_s[gi]),
      .out_data  (buf_data_s[gi]),
      .pop       (pop_s[gi])
    );
  end

  assign grant_data_s = buf_data_s[grant_idx_s];
  assign grant_eop_s  = grant_data_s[EOP_BIT];
  assign fire_s       = grant_valid_s && arb_ready_s;

  // Winner selection: the lock owner while a packet is open, otherwise the
  // first non-empty buffer at or after rr_ptr. Scanning from the far end lets
  // the closest candidate overwrite the others.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    scan_idx_s    = '0;
    if (locked_s) begin
      grant_valid_s = buf_valid_s[owner_r];
      grant_idx_s   = owner_r;
    end else begin
      for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
        scan_idx_s    = {1'b0, rr_ptr_r} + (SEL_W + 1)'(i);
        scan_idx_s    = (scan_idx_s >= NUM_IN_W) ? (scan_idx_s - NUM_IN_W) : scan_idx_s;
        grant_idx_s   = buf_valid_s[scan_idx_s[SEL_W-1:0]] ? scan_idx_s[SEL_W-1:0] : grant_idx_s;
        grant_valid_s = grant_valid_s | buf_valid_s[scan_idx_s[SEL_W-1:0]];
      end
    end
  end

  // Per-source pop strobe for the granted buffer
  always_comb begin
    pop_s = '0;
    if (fire_s) begin
      pop_s[grant_idx_s] = 1'b1;
    end else begin
      pop_s = '0;
    end
  end

  // Round-robin pointer successor of the current winner
  always_comb begin
    ptr_inc_s  = {1'b0, grant_idx_s} + {{SEL_W{1'b0}}, 1'b1};
    next_ptr_s = (ptr_inc_s >= NUM_IN_W) ? {SEL_W{1'b0}} : ptr_inc_s[SEL_W-1:0];
  end

  // Lock state register
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_state_r <= LOCK_IDLE;
    end else begin
      lock_state_r <= lock_next_s;
    end
  end

  // Lock next state: open on a non-final beat, close on the owner's eop
  always_comb begin
    lock_next_s = lock_state_r;
    case (lock_state_r)
      LOCK_IDLE:  lock_next_s = (fire_s && !grant_eop_s) ? LOCK_OWNED : LOCK_IDLE;
      LOCK_OWNED: lock_next_s = (fire_s && grant_eop_s) ? LOCK_IDLE : LOCK_OWNED;
      default:    lock_next_s = LOCK_IDLE;
    endcase
  end

  // Lock outputs
  always_comb begin
    locked_s = (lock_state_r == LOCK_OWNED);
  end

  // Packet owner and round-robin pointer; the pointer only moves at packet end
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_r  <= '0;
      rr_ptr_r <= '0;
    end else begin
      if (fire_s && !locked_s) begin
        owner_r <= grant_idx_s;
      end
      if (fire_s && grant_eop_s) begin
        rr_ptr_r <= next_ptr_s;
      end
    end
  end

  if (OUT_BUF != 0) begin : g_out_reg
    logic             out_valid_r;
    logic [DATAW-1:0] out_data_r;
    logic [SEL_W-1:0] out_sel_r;

    // Output register accepts a new beat when empty or being drained
    always_comb begin
      arb_ready_s = !out_valid_r || out_ready;
    end

    // Output register: data and source index move together
    always_ff @(posedge clk) begin
      if (reset) begin
        out_valid_r <= 1'b0;
        out_data_r  <= '0;
        out_sel_r   <= '0;
      end else if (arb_ready_s) begin
        out_valid_r <= grant_valid_s;
        out_data_r  <= grant_data_s;
        out_sel_r   <= grant_idx_s;
      end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sel   = out_sel_r;
  end else begin : g_out_comb
    // Without the output register the arbiter sees downstream ready directly
    always_comb begin
      arb_ready_s = out_ready;
    end

    assign out_valid = grant_valid_s;
    assign out_data  = grant_data_s;
    assign out_sel   = grant_idx_s;
  end

endmodule

// File: tb/tb_vx_result_merge.sv
module tb_vx_result_merge;
  import vx_result_merge_pkg::*;

  localparam int N  = 4;
  localparam int DW = result_dataw(RES_NUM_LANES, RES_PID_WIDTH);
  localparam int SW = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [N-1:0]            in_valid;
  logic [N-1:0][DW-1:0]    in_data;
  logic [N-1:0]            in_ready;
  logic                    out_valid;
  logic [DW-1:0]           out_data;
  logic [SW-1:0]           out_sel;
  logic                    out_ready;

  vx_result_merge #(.NUM_INPUTS(N), .OUT_BUF(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: per-source FIFOs of accepted-but-unserved beats plus the output register
  logic [DW-1:0] mq [N][$];
  logic [N-1:0]  m_ready;
  logic          m_ov;
  logic [DW-1:0] m_od;
  int            m_os, m_owner, m_rr;
  bit            m_lock;
  logic [N-1:0]  acc_bits;

  // Source drivers: a pending beat stays offered until accepted
  logic [N-1:0]  pend_valid;
  logic [DW-1:0] pend_data [N];
  int            gen_left [N];
  int            gen_pid [N];
  int            xfer_cnt, acc_cnt;
  int            sel_log [$];

  typedef struct {
    logic       v;
    logic [7:0] tag;
    logic       exp_v;
    logic [7:0] exp_tag;
  } vec_t;
  vec_t t1 [7];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_beat(input logic [7:0] tag, input int pid, input logic sop, input logic eop);
    logic [DW-1:0] b;
    b = '0;
    b[DW-1 -: 8] = tag;
    b[2 +: RES_PID_WIDTH] = RES_PID_WIDTH'(pid);
    b[1] = sop;
    b[0] = eop;
    return b;
  endfunction

  function automatic logic [DW-1:0] rand_beat(input int pid, input logic sop, input logic eop);
    logic [DW-1:0] b;
    for (int k = 0; k < DW; k++) b[k] = 1'($urandom_range(0, 1));
    b[2 +: RES_PID_WIDTH] = RES_PID_WIDTH'(pid);
    b[1] = sop;
    b[0] = eop;
    return b;
  endfunction

  task automatic offer(input int i, input logic [DW-1:0] beat);
    pend_valid[i] = 1'b1;
    pend_data[i]  = beat;
  endtask

  // Predict the state after the coming clock edge from the spec rules
  task automatic model_step();
    bit found;
    int w;
    acc_bits = '0;
    if (reset) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_ready = '0; m_ov = 1'b0; m_od = '0; m_os = 0; m_lock = 0; m_owner = 0; m_rr = 0;
    end else begin
      found = 0;
      w = 0;
      if (m_lock) begin
        if (mq[m_owner].size() > 0) begin found = 1; w = m_owner; end
      end else begin
        for (int k = 0; k < N; k++)
          if (!found && mq[(m_rr + k) % N].size() > 0) begin found = 1; w = (m_rr + k) % N; end
      end
      if (!m_ov || out_ready) begin
        m_ov = found;
        if (found) begin
          m_od = mq[w].pop_front();
          m_os = w;
          if (m_od[0]) begin m_lock = 0; m_rr = (w + 1) % N; end
          else begin m_lock = 1; m_owner = w; end
        end
      end
      for (int i = 0; i < N; i++)
        if (in_valid[i] && m_ready[i]) begin mq[i].push_back(in_data[i]); acc_bits[i] = 1'b1; end
      for (int i = 0; i < N; i++) m_ready[i] = (mq[i].size() < 2);
    end
  endtask

  task automatic tick();
    for (int i = 0; i < N; i++) begin
      in_valid[i] = pend_valid[i];
      in_data[i]  = pend_data[i];
    end
    if (out_valid && out_ready && !reset) begin
      xfer_cnt++;
      sel_log.push_back(int'(out_sel));
    end
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc_bits[i]) pend_valid[i] = 1'b0;
    acc_cnt += $countones(acc_bits);
    check("out_valid", 256'(out_valid), 256'(m_ov));
    if (m_ov) begin
      check("out_sel", 256'(out_sel), 256'(m_os));
      check("out_data", 256'(out_data), 256'(m_od));
    end
    check("in_ready", 256'(in_ready), 256'(m_ready));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    out_ready = 1'b1;
    pend_valid = '0;
    for (int i = 0; i < N; i++) begin gen_left[i] = 0; gen_pid[i] = 0; end
    tick();
    tick();
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_out_sel", 256'(out_sel), 256'(0));
    check("rst_in_ready", 256'(in_ready), 256'(0));
    reset = 1'b0;
    tick();
    check("rst_release_in_ready", 256'(in_ready), 256'(4'hF));
  endtask

  task automatic refill_single(input int i, input logic [7:0] tag);
    if (!pend_valid[i]) offer(i, mk_beat(tag, 0, 1'b1, 1'b1));
  endtask

  initial begin
    int k;
    int p1;
    reset = 1'b1;
    out_ready = 1'b1;
    in_valid = '0;
    in_data = '0;
    pend_valid = '0;
    for (int i = 0; i < N; i++) pend_data[i] = '0;
    m_ready = '0; m_ov = 1'b0; m_od = '0; m_os = 0; m_lock = 0; m_owner = 0; m_rr = 0;
    xfer_cnt = 0;
    acc_cnt = 0;

    // One source, four single-beat results back to back: visible two cycles after offer
    t1[0] = '{1'b1, 8'h10, 1'b0, 8'h00};
    t1[1] = '{1'b1, 8'h11, 1'b1, 8'h10};
    t1[2] = '{1'b1, 8'h12, 1'b1, 8'h11};
    t1[3] = '{1'b1, 8'h13, 1'b1, 8'h12};
    t1[4] = '{1'b0, 8'h00, 1'b1, 8'h13};
    t1[5] = '{1'b0, 8'h00, 1'b0, 8'h00};
    t1[6] = '{1'b0, 8'h00, 1'b0, 8'h00};
    do_reset();
    for (int r = 0; r < 7; r++) begin
      if (t1[r].v) offer(0, mk_beat(t1[r].tag, 0, 1'b1, 1'b1));
      tick();
      check("t1_valid", 256'(out_valid), 256'(t1[r].exp_v));
      if (t1[r].exp_v) begin
        check("t1_tag", 256'(out_data[DW-1 -: 8]), 256'(t1[r].exp_tag));
        check("t1_sel", 256'(out_sel), 256'(0));
      end
    end

    // All sources busy with single beats: strict rotation at one beat per cycle
    do_reset();
    for (int r = 0; r < 13; r++) begin
      for (int i = 0; i < N; i++) refill_single(i, 8'(i * 16 + r));
      tick();
      if (r >= 1) begin
        check("t2_valid", 256'(out_valid), 256'(1));
        check("t2_sel", 256'(out_sel), 256'((r - 1) % 4));
      end
    end
    for (int r = 0; r < 12; r++) tick();

    // Three-beat packet on source 1 stays contiguous, then rotation resumes at 2
    do_reset();
    sel_log.delete();
    p1 = 0;
    for (int r = 0; r < 12; r++) begin
      refill_single(0, 8'h20);
      refill_single(2, 8'h22);
      if (!pend_valid[1] && p1 < 3) begin
        offer(1, mk_beat(8'(8'h40 + p1), p1, p1 == 0, p1 == 2));
        p1++;
      end
      tick();
    end
    k = -1;
    for (int j = sel_log.size() - 1; j >= 0; j--) if (sel_log[j] == 1) k = j;
    check("t3_found", 256'((k >= 0) && (sel_log.size() >= k + 4)), 256'(1));
    if ((k >= 0) && (sel_log.size() >= k + 4)) begin
      check("t3_beat1", 256'(sel_log[k + 1]), 256'(1));
      check("t3_beat2", 256'(sel_log[k + 2]), 256'(1));
      check("t3_next", 256'(sel_log[k + 3]), 256'(2));
    end

    // Downstream stall: two beats per buffer plus one in the output register
    do_reset();
    out_ready = 1'b0;
    acc_cnt = 0;
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < N; i++) refill_single(i, 8'(8'h80 + i * 16 + r));
      tick();
    end
    check("t4_accepted", 256'(acc_cnt), 256'(9));
    check("t4_in_ready", 256'(in_ready), 256'(0));
    out_ready = 1'b1;
    xfer_cnt = 0;
    for (int r = 0; r < 20; r++) tick();
    check("t4_drained", 256'(xfer_cnt), 256'(13));

    // Locked owner gap: bubbles on the output, no other source served
    do_reset();
    for (int r = 0; r < 9; r++) begin
      refill_single(0, 8'h50);
      refill_single(2, 8'h52);
      if (r == 0) offer(1, mk_beat(8'h60, 0, 1'b1, 1'b0));
      if (r == 5) offer(1, mk_beat(8'h61, 1, 1'b0, 1'b1));
      tick();
      if (r >= 3 && r <= 5) check("t5_gap", 256'(out_valid), 256'(0));
      if (r == 6) begin
        check("t5_owner_valid", 256'(out_valid), 256'(1));
        check("t5_owner_sel", 256'(out_sel), 256'(1));
      end
      if (r == 7) check("t5_next_sel", 256'(out_sel), 256'(2));
    end
    for (int r = 0; r < 12; r++) tick();

    // Reset in the middle of a packet drops it and clears the lock
    do_reset();
    offer(1, mk_beat(8'h70, 0, 1'b1, 1'b0));
    tick();
    offer(1, mk_beat(8'h71, 1, 1'b0, 1'b0));
    tick();
    check("t6_locked_sel", 256'(out_sel), 256'(1));
    reset = 1'b1;
    tick();
    check("t6_rst_valid", 256'(out_valid), 256'(0));
    check("t6_rst_ready", 256'(in_ready), 256'(0));
    pend_valid = '0;
    reset = 1'b0;
    tick();
    check("t6_ready_back", 256'(in_ready), 256'(4'hF));
    offer(3, mk_beat(8'h77, 0, 1'b1, 1'b1));
    tick();
    tick();
    check("t6_new_valid", 256'(out_valid), 256'(1));
    check("t6_new_sel", 256'(out_sel), 256'(3));
    check("t6_new_tag", 256'(out_data[DW-1 -: 8]), 256'(8'h77));

    // Random traffic with multi-beat packets, gaps and backpressure
    do_reset();
    for (int r = 0; r < 1500; r++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) begin
        if (!pend_valid[i] && $urandom_range(0, 3) != 0) begin
          if (gen_left[i] == 0) begin
            gen_left[i] = $urandom_range(1, 3);
            gen_pid[i] = 0;
          end
          offer(i, rand_beat(gen_pid[i], gen_pid[i] == 0, gen_left[i] == 1));
          gen_left[i]--;
          gen_pid[i]++;
        end
      end
      tick();
    end
    out_ready = 1'b1;
    for (int r = 0; r < 20; r++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
